hybridcache_ctrl: RTL and testbench
===================================

# hybridcache_ctrl

Refill controller for the hybrid cache: watches a bank of NLINES `cache_line` instances, detects a global miss (every line reports miss), picks the victim line with the lowest TTL, flushes it if dirty, then refills it with the region containing the missing address. Sits directly upstream of the `cache_line` controller ports (`cache_line_flush`, `cache_line_fill`, `cache_line_pause`, `cache_new_region`) and consumes their `cache_line_dirty`, `cache_line_miss`, `cache_line_ttl` and `cache_line_ready` outputs.

## Interface
- ADDRBITS, 32, address width
- LSBBITS, 7, byte-offset bits inside one line region
- TTLBITS, 8, width of each line's TTL
- NLINES, 4, number of cache lines managed (2..16)
- LINEBITS, 2, index width, equals ceil(log2(NLINES))

Ports:
- clk  in  1  system clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- ctrl_miss_addr  in  ADDRBITS  address of the outstanding missed access
- line_miss  in  NLINES  per-line `cache_line_miss`
- line_dirty  in  NLINES  per-line `cache_line_dirty`
- line_ttl  in  NLINES*TTLBITS  per-line TTL, line i at [i*TTLBITS +: TTLBITS]
- line_ready  in  NLINES  per-line `cache_line_ready`
- mem_busy  in  1  memory controller overloaded
- line_flush  out  NLINES  one-hot flush pulse
- line_fill  out  NLINES  one-hot fill pulse
- line_pause  out  NLINES  per-line pause
- cache_new_region  out  ADDRBITS  region base for the fill, shared by all lines
- ctrl_busy  out  1  refill sequence in progress
- ctrl_victim  out  LINEBITS  index of the current/last victim
- ctrl_refills  out  16  completed refills, saturating
- ctrl_flushes  out  16  flushes issued, saturating

## Operation
- States: IDLE, SELECT, FLUSH, FLUSH_GUARD, FLUSH_WAIT, FILL, FILL_GUARD, FILL_WAIT.
- IDLE: if &line_miss, capture region = {ctrl_miss_addr[ADDRBITS-1:LSBBITS], LSBBITS zeros} -> SELECT. Otherwise stay.
- SELECT: victim = index with minimum TTL; ties go to lowest index. Register ctrl_victim. -> FLUSH if line_dirty[victim], else FILL.
- FLUSH: line_flush[victim]=1 for exactly this cycle; ctrl_flushes++ -> FLUSH_GUARD.
- FLUSH_GUARD: one cycle, line_ready ignored -> FLUSH_WAIT.
- FLUSH_WAIT: stay until line_ready[victim]=1 -> FILL.
- FILL: line_fill[victim]=1 for exactly this cycle; cache_new_region = captured region -> FILL_GUARD.
- FILL_GUARD: one cycle, ready ignored -> FILL_WAIT.
- FILL_WAIT: stay until line_ready[victim]=1; ctrl_refills++ -> IDLE.
- cache_new_region: updated only on entering FILL, then held until the next FILL (stable for the whole fill).
- Once captured, the sequence always completes; changes on line_miss/ctrl_miss_addr after the capture edge are ignored.
- line_pause[i] = mem_busy for every line (registered, one cycle delay); the sequencer does not stall on mem_busy, lines handle pause themselves.
- ctrl_busy = (state != IDLE).
- Counters saturate at 16'hFFFF, never wrap.
- line_flush and line_fill are never both high, and never high for more than one line.

## Timing
- Reset (async, reset_n=0): state IDLE; line_flush, line_fill, line_pause = 0; cache_new_region = 0; ctrl_busy = 0; ctrl_victim = 0; both counters = 0. Reset mid-sequence aborts immediately, no pulse is completed.
- All outputs registered (no combinational input-to-output path).
- Clean miss: all-miss sampled at edge E0 -> SELECT; E1 -> FILL, line_fill high E1..E2; FILL_GUARD E2..E3; ready sampled from E3; earliest return to IDLE at E4.
- Dirty miss: line_flush high E1..E2; ready sampled from E3; line_fill high at earliest E4..E5; earliest IDLE at E7.
- Back-to-back: in IDLE the cycle after a completed refill, a still-asserted &line_miss starts a new sequence (one idle cycle minimum between sequences).
- No timeout: a line never raising ready holds the controller in the WAIT state indefinitely.

## Test plan
- Reset: reset_n low mid-FILL_WAIT -> all outputs 0, ctrl_busy 0 immediately, IDLE after release.
- Clean refill: NLINES=4, TTL {40,10,30,20}, all miss, none dirty, ctrl_miss_addr=32'h0000_12F4, ready returns 3 cycles after fill -> line_fill=4'b0010, cache_new_region=32'h0000_1280, no flush, ctrl_refills=1.
- Dirty refill: victim line 2 dirty -> line_flush=4'b0100 one cycle, fill only after ready[2]=1 post-guard, ctrl_flushes=1, ctrl_refills=1.
- TTL tie: TTL {5,5,5,5} -> victim 0; TTL {9,3,3,7} -> victim 1.
- Partial miss: line_miss=4'b1110 for 20 cycles -> ctrl_busy stays 0, no pulses.
- Saturation and pause: preload 65535 refills (or force counter) then one more -> ctrl_refills stays 16'hFFFF; mem_busy=1 -> line_pause=4'b1111 one cycle later.

Source files
------------

// File: rtl/hybridcache_ctrl.sv
// Refill controller for the hybrid cache: on a global miss it picks the lowest-TTL line,
// flushes it if dirty, then refills it with the region holding the missed address.
module hybridcache_ctrl #(
  parameter int unsigned ADDRBITS = 32,
  parameter int unsigned LSBBITS  = 7,
  parameter int unsigned TTLBITS  = 8,
  parameter int unsigned NLINES   = 4,
  parameter int unsigned LINEBITS = 2
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [ADDRBITS-1:0]         ctrl_miss_addr,
  input  logic [NLINES-1:0]           line_miss,
  input  logic [NLINES-1:0]           line_dirty,
  input  logic [NLINES*TTLBITS-1:0]   line_ttl,
  input  logic [NLINES-1:0]           line_ready,
  input  logic                        mem_busy,
  output logic [NLINES-1:0]           line_flush,
  output logic [NLINES-1:0]           line_fill,
  output logic [NLINES-1:0]           line_pause,
  output logic [ADDRBITS-1:0]         cache_new_region,
  output logic                        ctrl_busy,
  output logic [LINEBITS-1:0]         ctrl_victim,
  output logic [15:0]                 ctrl_refills,
  output logic [15:0]                 ctrl_flushes
);

  localparam logic [2:0] StIdle       = 3'd0;
  localparam logic [2:0] StSelect     = 3'd1;
  localparam logic [2:0] StFlush      = 3'd2;
  localparam logic [2:0] StFlushGuard = 3'd3;
  localparam logic [2:0] StFlushWait  = 3'd4;
  localparam logic [2:0] StFill       = 3'd5;
  localparam logic [2:0] StFillGuard  = 3'd6;
  localparam logic [2:0] StFillWait   = 3'd7;

  localparam logic [NLINES-1:0] OneLsb = NLINES'(1);

  logic [2:0]          state_q, state_d;
  logic [LINEBITS-1:0] victim_q, victim_d;
  logic [ADDRBITS-1:0] capt_q, capt_d;
  logic [ADDRBITS-1:0] region_q, region_d;
  logic [NLINES-1:0]   flush_q, flush_d;
  logic [NLINES-1:0]   fill_q, fill_d;
  logic [NLINES-1:0]   pause_q;
  logic [15:0]         refills_q, refills_d;
  logic [15:0]         flushes_q, flushes_d;

  logic [LINEBITS-1:0] sel_idx;
  logic [TTLBITS-1:0]  sel_ttl;

  // Strict less-than keeps the lowest index on TTL ties.
  always_comb begin
    sel_idx = '0;
    sel_ttl = line_ttl[0 +: TTLBITS];
    for (int i = 1; i < int'(NLINES); i++) begin
      if (line_ttl[i*TTLBITS +: TTLBITS] < sel_ttl) begin
        sel_ttl = line_ttl[i*TTLBITS +: TTLBITS];
        sel_idx = LINEBITS'(i);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    victim_d  = victim_q;
    capt_d    = capt_q;
    region_d  = region_q;
    flush_d   = '0;
    fill_d    = '0;
    refills_d = refills_q;
    flushes_d = flushes_q;
    case (state_q)
      StIdle: begin
        if (&line_miss) begin
          capt_d  = {ctrl_miss_addr[ADDRBITS-1:LSBBITS], {LSBBITS{1'b0}}};
          state_d = StSelect;
        end
      end
      StSelect: begin
        victim_d = sel_idx;
        if (line_dirty[sel_idx]) begin
          flush_d   = OneLsb << sel_idx;
          flushes_d = (flushes_q == 16'hFFFF) ? flushes_q : flushes_q + 16'd1;
          state_d   = StFlush;
        end else begin
          fill_d   = OneLsb << sel_idx;
          region_d = capt_q;
          state_d  = StFill;
        end
      end
      StFlush:      state_d = StFlushGuard;
      StFlushGuard: state_d = StFlushWait;
      StFlushWait: begin
        if (line_ready[victim_q]) begin
          fill_d   = OneLsb << victim_q;
          region_d = capt_q;
          state_d  = StFill;
        end
      end
      StFill:      state_d = StFillGuard;
      StFillGuard: state_d = StFillWait;
      StFillWait: begin
        if (line_ready[victim_q]) begin
          refills_d = (refills_q == 16'hFFFF) ? refills_q : refills_q + 16'd1;
          state_d   = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      victim_q  <= '0;
      capt_q    <= '0;
      region_q  <= '0;
      flush_q   <= '0;
      fill_q    <= '0;
      pause_q   <= '0;
      refills_q <= '0;
      flushes_q <= '0;
    end else begin
      state_q   <= state_d;
      victim_q  <= victim_d;
      capt_q    <= capt_d;
      region_q  <= region_d;
      flush_q   <= flush_d;
      fill_q    <= fill_d;
      pause_q   <= {NLINES{mem_busy}};
      refills_q <= refills_d;
      flushes_q <= flushes_d;
    end
  end

  assign line_flush       = flush_q;
  assign line_fill        = fill_q;
  assign line_pause       = pause_q;
  assign cache_new_region = region_q;
  assign ctrl_busy        = (state_q != StIdle);
  assign ctrl_victim      = victim_q;
  assign ctrl_refills     = refills_q;
  assign ctrl_flushes     = flushes_q;

endmodule

// File: tb/tb_hybridcache_ctrl.sv
// Randomized bench for hybridcache_ctrl: each refill is predicted from the victim rule and
// the per-phase cycle schedule, with flush/refill counts kept by a saturating model.
module tb_hybridcache_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] ctrl_miss_addr;
  logic [3:0]  line_miss, line_dirty, line_ready;
  logic [31:0] line_ttl;
  logic        mem_busy;
  logic [3:0]  line_flush, line_fill, line_pause;
  logic [31:0] cache_new_region;
  logic        ctrl_busy;
  logic [1:0]  ctrl_victim;
  logic [15:0] ctrl_refills, ctrl_flushes;

  int n_tests = 0;
  int n_fail  = 0;
  logic        mb_drv;
  int unsigned exp_ref, exp_fl;

  hybridcache_ctrl #(
    .ADDRBITS(32), .LSBBITS(7), .TTLBITS(8), .NLINES(4), .LINEBITS(2)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .ctrl_miss_addr   (ctrl_miss_addr),
    .line_miss        (line_miss),
    .line_dirty       (line_dirty),
    .line_ttl         (line_ttl),
    .line_ready       (line_ready),
    .mem_busy         (mem_busy),
    .line_flush       (line_flush),
    .line_fill        (line_fill),
    .line_pause       (line_pause),
    .cache_new_region (cache_new_region),
    .ctrl_busy        (ctrl_busy),
    .ctrl_victim      (ctrl_victim),
    .ctrl_refills     (ctrl_refills),
    .ctrl_flushes     (ctrl_flushes)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Advance to the next falling edge; check pause lag and pulse exclusivity every cycle.
  task automatic tick();
    @(negedge clk);
    check_eq("pause", {28'd0, line_pause}, {28'd0, {4{mb_drv}}});
    check_eq("pulse_excl", 32'($countones(line_flush | line_fill) <= 1 &&
                               (line_flush & line_fill) == 4'd0), 32'd1);
    mb_drv   = 1'($urandom);
    mem_busy = mb_drv;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_flush"},  {28'd0, line_flush}, 32'd0);
    check_eq({tag, "_fill"},   {28'd0, line_fill}, 32'd0);
    check_eq({tag, "_pause"},  {28'd0, line_pause}, 32'd0);
    check_eq({tag, "_region"}, cache_new_region, 32'd0);
    check_eq({tag, "_busy"},   {31'd0, ctrl_busy}, 32'd0);
    check_eq({tag, "_victim"}, {30'd0, ctrl_victim}, 32'd0);
    check_eq({tag, "_refills"}, {16'd0, ctrl_refills}, 32'd0);
    check_eq({tag, "_flushes"}, {16'd0, ctrl_flushes}, 32'd0);
  endtask

  // Pulse cycle -> guard -> wait d cycles -> ready[v] sampled. Ready[v] is held high
  // through the pulse and guard cycles, where it must be ignored.
  task automatic wait_phase(input string tag, input int d, input logic [3:0] oh,
                            input bit abort, output bit aborted);
    aborted = 1'b0;
    line_ready = line_ready | oh;
    tick();
    check_eq({tag, "_pulse_end"}, {28'd0, line_flush | line_fill}, 32'd0);
    check_eq({tag, "_busy_guard"}, {31'd0, ctrl_busy}, 32'd1);
    tick();
    check_eq({tag, "_busy_wait"}, {31'd0, ctrl_busy}, 32'd1);
    if (abort) begin
      tick();
      reset_n = 1'b0;
      #1;
      check_reset_outputs("abort");
      exp_ref = 0;
      exp_fl  = 0;
      mb_drv   = 1'b0;
      mem_busy = 1'b0;
      line_miss  = 4'd0;
      line_ready = 4'd0;
      @(negedge clk);
      reset_n = 1'b1;
      tick();
      check_eq("abort_idle", {31'd0, ctrl_busy}, 32'd0);
      aborted = 1'b1;
      return;
    end
    for (int k = 0; k < d; k++) begin
      line_ready = 4'($urandom) & ~oh;
      tick();
      check_eq({tag, "_hold"}, {27'd0, ctrl_busy, line_flush | line_fill}, 32'h10);
    end
    line_ready = 4'($urandom) | oh;
    tick();
  endtask

  task automatic do_seq(input logic [31:0] ttl, input logic [3:0] dirty, input logic [31:0] addr,
                        input int dfl, input int dfi, input bit abort);
    int          v;
    int unsigned mn;
    logic [3:0]  oh;
    logic [31:0] region;
    bit          ab;
    mn = 256;
    for (int i = 0; i < 4; i++) if (int'(ttl[i*8 +: 8]) < mn) mn = ttl[i*8 +: 8];
    v = 0;
    for (int i = 3; i >= 0; i--) if (int'(ttl[i*8 +: 8]) == mn) v = i;
    oh     = 4'b0001 << v;
    region = addr & ~32'h7F;

    line_ttl = ttl; line_dirty = dirty; ctrl_miss_addr = addr; line_miss = 4'hF;
    line_ready = 4'($urandom) & ~oh;
    tick();
    check_eq("select_busy", {31'd0, ctrl_busy}, 32'd1);
    check_eq("select_nopulse", {28'd0, line_flush | line_fill}, 32'd0);
    // Post-capture changes must be ignored.
    line_miss = 4'($urandom) & 4'hE;
    ctrl_miss_addr = $urandom;
    tick();
    check_eq("victim", {30'd0, ctrl_victim}, v);
    line_dirty = 4'($urandom);
    line_ttl   = $urandom;
    if (dirty[v]) begin
      if (exp_fl < 32'hFFFF) exp_fl++;
      check_eq("flush_pulse", {24'd0, line_flush, line_fill}, {24'd0, oh, 4'd0});
      wait_phase("flush", dfl, oh, 1'b0, ab);
    end
    check_eq("fill_pulse", {24'd0, line_flush, line_fill}, {28'd0, oh});
    check_eq("fill_region", cache_new_region, region);
    wait_phase("fill", dfi, oh, abort, ab);
    if (ab) return;
    if (exp_ref < 32'hFFFF) exp_ref++;
    check_eq("done_busy", {31'd0, ctrl_busy}, 32'd0);
    check_eq("done_region", cache_new_region, region);
    check_eq("refills", {16'd0, ctrl_refills}, exp_ref);
    check_eq("flushes", {16'd0, ctrl_flushes}, exp_fl);
    line_miss  = 4'd0;
    line_ready = 4'd0;
  endtask

  initial begin
    logic [31:0] t;
    reset_n = 1'b0; ctrl_miss_addr = '0; line_miss = '0; line_dirty = '0;
    line_ttl = '0; line_ready = '0; mem_busy = 1'b0; mb_drv = 1'b0;
    exp_ref = 0; exp_fl = 0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    reset_n = 1'b1;
    tick();

    // Clean refill: TTL {40,10,30,20}, victim 1, region 0x1280.
    do_seq({8'd20, 8'd30, 8'd10, 8'd40}, 4'b0000, 32'h0000_12F4, 0, 2, 1'b0);
    // Dirty refill on line 2.
    do_seq({8'd70, 8'd5, 8'd60, 8'd50}, 4'b0100, 32'hDEAD_BEEF, 2, 1, 1'b0);
    // Ties.
    do_seq({8'd5, 8'd5, 8'd5, 8'd5}, 4'($urandom), $urandom, 1, 0, 1'b0);
    do_seq({8'd7, 8'd3, 8'd3, 8'd9}, 4'($urandom), $urandom, 0, 3, 1'b0);

    // Partial miss never starts a sequence.
    line_miss = 4'b1110;
    for (int k = 0; k < 20; k++) begin
      tick();
      check_eq("partial", {27'd0, ctrl_busy, line_flush | line_fill}, 32'd0);
    end
    line_miss = 4'd0;

    mem_busy = 1'b1; mb_drv = 1'b1;
    tick();
    check_eq("pause_all", {28'd0, line_pause}, 32'hF);

    for (int n = 0; n < 40; n++) begin
      t = $urandom;
      if (n % 2 == 0) t = t & 32'h0303_0303;
      do_seq(t, 4'($urandom), $urandom, $urandom_range(0, 4), $urandom_range(0, 4), 1'b0);
    end

    // Reset mid fill-wait, then a normal refill afterwards.
    do_seq({8'd1, 8'd2, 8'd3, 8'd4}, 4'b1111, $urandom, 1, 2, 1'b1);
    do_seq($urandom, 4'($urandom), $urandom, 1, 1, 1'b0);

    // Saturation.
    force dut.refills_q = 16'hFFFF;
    force dut.flushes_q = 16'hFFFE;
    tick();
    release dut.refills_q;
    release dut.flushes_q;
    exp_ref = 32'hFFFF;
    exp_fl  = 32'hFFFE;
    tick();
    check_eq("sat_preload", {ctrl_refills, ctrl_flushes}, 32'hFFFF_FFFE);
    do_seq({8'd9, 8'd9, 8'd1, 8'd9}, 4'b1111, $urandom, 0, 0, 1'b0);
    do_seq({8'd0, 8'd9, 8'd9, 8'd9}, 4'b1111, $urandom, 1, 1, 1'b0);
    check_eq("sat_final", {ctrl_refills, ctrl_flushes}, 32'hFFFF_FFFF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
